fx_bus_hub: RTL and testbench
=============================

// Module: fx_bus_hub
// PURPOSE
//  Parametrised successor of the flat fx bus. Connects the UART fx master to NSLV slaves
//  (con, ad1..8, dsp1..8 = 17). Registers master requests and decodes a one-hot slave select
//  from the address. Read data is muxed from the selected slave only, not wired-OR.
//  Adds read-latency tracking, a read-valid strobe, busy back-pressure and a default read value
//  for unmapped addresses.
// PARAMETERS
//  NSLV     17      number of slaves (1..32)
//  AW       22      fx address width
//  DW       8       fx data width
//  SEL_LSB  17      lowest address bit of the slave index field
//  SELW     5       slave index field width; index = addr[SEL_LSB+SELW-1:SEL_LSB]
//  RD_LAT   1       slave read latency: cycles from fx_rd to valid slv_q (1..7)
//  DFLT_Q   8'hEE   ufx_q value returned for a read to an unmapped index
// PORTS
//  clk_sys    in   1        system clock
//  rst_n      in   1        asynchronous active-low reset
//  ufx_wr     in   1        master write strobe, 1-cycle pulse
//  ufx_waddr  in   AW       master write address
//  ufx_data   in   DW       master write data
//  ufx_rd     in   1        master read strobe, 1-cycle pulse
//  ufx_raddr  in   AW       master read address
//  ufx_q      out  DW       read data, held until the next read completes
//  ufx_qvld   out  1        1-cycle pulse: ufx_q updated
//  ufx_busy   out  1        hub cannot accept a new request
//  fx_wr      out  1        slave write strobe (registered)
//  fx_waddr   out  AW       slave write address (registered)
//  fx_data    out  DW       slave write data (registered)
//  fx_rd      out  1        slave read strobe (registered)
//  fx_raddr   out  AW       slave read address (registered)
//  fx_sel     out  NSLV     one-hot slave select, valid with fx_wr/fx_rd
//  slv_q      in   NSLV*DW  flat slave read data, slave i at [i*DW +: DW]
//  err_cnt    out  16       FX_BUS_ERRCNT_EN only: error count
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> IDLE, pending read cleared. Reset mid-read aborts the read;
//    no ufx_qvld is issued.
//  - FSM states: IDLE, ISSUE, RWAIT, RDONE.
//  - IDLE, request arrives at cycle t: the FSM goes to ISSUE. At t+1 fx_wr/fx_rd pulse for
//    1 cycle with the address, data and fx_sel registered from cycle t.
//  - Writes: ISSUE -> IDLE. ufx_busy is high only at t+1, so back-to-back writes run every
//    2 cycles.
//  - Reads: ISSUE -> RWAIT, which counts RD_LAT cycles.
//    - At t+1+RD_LAT the hub samples slv_q of the latched index, then RDONE.
//    - At t+2+RD_LAT: ufx_q loads, ufx_qvld pulses, FSM -> IDLE.
//    - ufx_busy is high from t+1 through t+2+RD_LAT inclusive.
//  - Simultaneous ufx_wr and ufx_rd in IDLE:
//    - the write issues first;
//    - the read address is latched as pending;
//    - the read issues the cycle after the write (fx_rd at t+2);
//    - read timing then shifts by one cycle.
//  - Requests that arrive while ufx_busy=1 are ignored (protocol error).
//  - Decode:
//    - index >= NSLV is unmapped;
//    - for an unmapped access fx_sel=0 while fx_wr/fx_rd still pulse;
//    - an unmapped read returns DFLT_Q with normal timing.
//  - fx_sel is zero whenever neither fx_wr nor fx_rd is high.
//  - Unselected slv_q lanes are don't-care.
// CONFIGURATION
//  - FX_BUS_ERRCNT_EN defined:
//    - err_cnt port exists;
//    - it increments by 1 per unmapped access and per request ignored while busy;
//    - it saturates at 16'hFFFF and resets to 0;
//    - a dropped request that is also unmapped counts once.
//  - FX_BUS_ERRCNT_EN undefined: no err_cnt port and no counter logic. All other behaviour
//    is identical.
// TESTING  (NSLV=17, RD_LAT=1, SEL_LSB=17)
//  1. ufx_wr, waddr=22'h040010 (idx 2), data=8'h5A
//     -> at t+1: fx_wr=1, fx_sel=17'h00004, fx_data=8'h5A; ufx_busy=1 for 1 cycle.
//  2. ufx_rd, raddr=22'h200004 (idx 16), slv_q lane16=8'hC3
//     -> fx_rd at t+1, ufx_qvld at t+3 with ufx_q=8'hC3, other lanes=8'hFF ignored.
//  3. ufx_wr (idx 1) and ufx_rd (idx 3) in the same cycle
//     -> fx_wr at t+1, fx_rd at t+2, ufx_qvld at t+4.
//  4. ufx_rd, raddr=22'h3E0000 (idx 31)
//     -> fx_sel=0, ufx_q=8'hEE at t+3; err_cnt 0->1 when the macro is defined.
//  5. Second ufx_rd at t+1 during a read
//     -> ignored, only one fx_rd pulse; err_cnt +1 when the macro is defined.
//  6. rst_n low at t+2 of a read
//     -> all outputs 0 immediately, no ufx_qvld.
//     -> after release, a read of idx 0 completes normally.

Source files
------------

// File: rtl/fx_bus_hub.sv
// rtl/fx_bus_hub.sv - fx bus hub: registered master requests, one-hot slave decode, muxed read return
// Optional error counter on err_cnt when FX_BUS_ERRCNT_EN is defined.
module fx_bus_hub #(
    parameter int NSLV    = 17,
    parameter int AW      = 22,
    parameter int DW      = 8,
    parameter int SEL_LSB = 17,
    parameter int SELW    = 5,
    parameter int RD_LAT  = 1,
    parameter logic [DW-1:0] DFLT_Q = 8'hEE
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic                 ufx_wr,
    input  logic [AW-1:0]        ufx_waddr,
    input  logic [DW-1:0]        ufx_data,
    input  logic                 ufx_rd,
    input  logic [AW-1:0]        ufx_raddr,
    output logic [DW-1:0]        ufx_q,
    output logic                 ufx_qvld,
    output logic                 ufx_busy,
    output logic                 fx_wr,
    output logic [AW-1:0]        fx_waddr,
    output logic [DW-1:0]        fx_data,
    output logic                 fx_rd,
    output logic [AW-1:0]        fx_raddr,
    output logic [NSLV-1:0]      fx_sel,
    input  logic [NSLV*DW-1:0]   slv_q
`ifdef FX_BUS_ERRCNT_EN
    ,
    output logic [15:0]          err_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RWAIT,
        S_RDONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            op_rd;
    logic            pend_rd;
    logic [AW-1:0]   pend_raddr;
    logic [2:0]      lat_cnt;
    logic [SELW-1:0] rd_idx;
    logic            rd_map;

    logic            go_wr;
    logic            go_rd;
    logic            rd_from_pend;
    logic            set_pend;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cap_q;
    logic [AW-1:0]   rd_addr_sel;
    logic [DW-1:0]   lane_q;

    function automatic logic [SELW-1:0] idx_of(input logic [AW-1:0] a);
        return a[SEL_LSB +: SELW];
    endfunction

    function automatic logic is_mapped(input logic [AW-1:0] a);
        return int'(idx_of(a)) < NSLV;
    endfunction

    function automatic logic [NSLV-1:0] decode(input logic [AW-1:0] a);
        logic [NSLV-1:0] sel;
        sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (int'(idx_of(a)) == i) sel[i] = 1'b1;
        end
        return sel;
    endfunction

    assign ufx_busy    = (state != S_IDLE);
    assign rd_addr_sel = rd_from_pend ? pend_raddr : ufx_raddr;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // A write wins a simultaneous request; the read then re-enters ISSUE from the pending slot.
    always_comb begin
        state_nxt    = state;
        go_wr        = 1'b0;
        go_rd        = 1'b0;
        rd_from_pend = 1'b0;
        set_pend     = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cap_q        = 1'b0;
        case (state)
            S_IDLE: begin
                if (ufx_wr) begin
                    go_wr     = 1'b1;
                    set_pend  = ufx_rd;
                    state_nxt = S_ISSUE;
                end else if (ufx_rd) begin
                    go_rd     = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!op_rd && pend_rd) begin
                    go_rd        = 1'b1;
                    rd_from_pend = 1'b1;
                end else if (op_rd) begin
                    cnt_load  = 1'b1;
                    state_nxt = S_RWAIT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RWAIT: begin
                if (lat_cnt == 3'd0) begin
                    cap_q     = 1'b1;
                    state_nxt = S_RDONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_RDONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        lane_q = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (int'(rd_idx) == i) lane_q = slv_q[i*DW +: DW];
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fx_wr      <= 1'b0;
            fx_rd      <= 1'b0;
            fx_sel     <= '0;
            fx_waddr   <= '0;
            fx_data    <= '0;
            fx_raddr   <= '0;
            op_rd      <= 1'b0;
            pend_rd    <= 1'b0;
            pend_raddr <= '0;
            lat_cnt    <= '0;
            rd_idx     <= '0;
            rd_map     <= 1'b0;
            ufx_q      <= '0;
            ufx_qvld   <= 1'b0;
        end else begin
            fx_wr    <= go_wr;
            fx_rd    <= go_rd;
            ufx_qvld <= cap_q;
            if (go_wr)      fx_sel <= decode(ufx_waddr);
            else if (go_rd) fx_sel <= decode(rd_addr_sel);
            else            fx_sel <= '0;
            if (go_wr) begin
                fx_waddr <= ufx_waddr;
                fx_data  <= ufx_data;
                op_rd    <= 1'b0;
            end
            if (go_rd) begin
                fx_raddr <= rd_addr_sel;
                rd_idx   <= idx_of(rd_addr_sel);
                rd_map   <= is_mapped(rd_addr_sel);
                op_rd    <= 1'b1;
            end
            if (set_pend) begin
                pend_rd    <= 1'b1;
                pend_raddr <= ufx_raddr;
            end else if (rd_from_pend) begin
                pend_rd <= 1'b0;
            end
            if (cnt_load)     lat_cnt <= 3'(RD_LAT - 1);
            else if (cnt_dec) lat_cnt <= lat_cnt - 3'd1;
            if (cap_q) ufx_q <= rd_map ? lane_q : DFLT_Q;
        end
    end

`ifdef FX_BUS_ERRCNT_EN
    // Dropped requests are counted without decoding, so a dropped unmapped request counts once.
    logic [2:0]  err_inc;
    logic [16:0] err_sum;

    always_comb begin
        err_inc = 3'd0;
        if (go_wr && !is_mapped(ufx_waddr))   err_inc = err_inc + 3'd1;
        if (go_rd && !is_mapped(rd_addr_sel)) err_inc = err_inc + 3'd1;
        if (ufx_busy && ufx_wr)               err_inc = err_inc + 3'd1;
        if (ufx_busy && ufx_rd)               err_inc = err_inc + 3'd1;
        err_sum = {1'b0, err_cnt} + {14'd0, err_inc};
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)          err_cnt <= '0;
        else if (err_sum[16]) err_cnt <= 16'hFFFF;
        else                 err_cnt <= err_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_fx_bus_hub.sv
// tb/tb_fx_bus_hub.sv - scoreboard bench for fx_bus_hub with a cycle-level reference model
module tb_fx_bus_hub;
    localparam int NSLV   = 17;
    localparam int AW     = 22;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;
    localparam logic [DW-1:0] DFLT = 8'hEE;

    logic               clk_sys = 1'b0;
    logic               rst_n   = 1'b0;
    logic               ufx_wr  = 1'b0;
    logic [AW-1:0]      ufx_waddr = '0;
    logic [DW-1:0]      ufx_data  = '0;
    logic               ufx_rd  = 1'b0;
    logic [AW-1:0]      ufx_raddr = '0;
    logic [DW-1:0]      ufx_q;
    logic               ufx_qvld;
    logic               ufx_busy;
    logic               fx_wr;
    logic [AW-1:0]      fx_waddr;
    logic [DW-1:0]      fx_data;
    logic               fx_rd;
    logic [AW-1:0]      fx_raddr;
    logic [NSLV-1:0]    fx_sel;
    logic [NSLV*DW-1:0] slv_q = '0;
`ifdef FX_BUS_ERRCNT_EN
    logic [15:0]        err_cnt;
`endif

    fx_bus_hub dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .ufx_wr    (ufx_wr),
        .ufx_waddr (ufx_waddr),
        .ufx_data  (ufx_data),
        .ufx_rd    (ufx_rd),
        .ufx_raddr (ufx_raddr),
        .ufx_q     (ufx_q),
        .ufx_qvld  (ufx_qvld),
        .ufx_busy  (ufx_busy),
        .fx_wr     (fx_wr),
        .fx_waddr  (fx_waddr),
        .fx_data   (fx_data),
        .fx_rd     (fx_rd),
        .fx_raddr  (fx_raddr),
        .fx_sel    (fx_sel),
        .slv_q     (slv_q)
`ifdef FX_BUS_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        bit              is_rd;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [NSLV-1:0] sel;
    } fx_ev_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] q;
    } q_ev_t;

    fx_ev_t exp_fx[$];
    q_ev_t  exp_q[$];
    int     n_checks  = 0;
    int     n_fail    = 0;
    int     busy_from = -10;
    int     busy_to   = -10;
    int     slv_cycle = -10;
    int     exp_err   = 0;
    logic [NSLV*DW-1:0] slv_val = '0;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int ref_idx(input logic [AW-1:0] a);
        return int'(a >> 17) & 31;
    endfunction

    function automatic logic [NSLV-1:0] ref_sel(input logic [AW-1:0] a);
        logic [NSLV-1:0] one;
        one = 1;
        return (ref_idx(a) < NSLV) ? (one << ref_idx(a)) : '0;
    endfunction

    // Slaves present valid data only in the cycle the hub must sample; garbage otherwise.
    always @(posedge clk_sys) begin
        #1;
        if (cyc == slv_cycle) slv_q = slv_val;
        else for (int i = 0; i < NSLV; i++) slv_q[i*DW +: DW] = 8'($urandom);
    end

    fx_ev_t m_e;
    q_ev_t  m_q;
    logic [63:0] m_act, m_exp;
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (fx_wr || fx_rd) begin
                m_act = {cyc[15:0], fx_rd, fx_sel, fx_rd ? fx_raddr : fx_waddr, fx_rd ? 8'h00 : fx_data};
                if (exp_fx.size() == 0) begin
                    check("fx_unexpected", 1'b0, m_act, 64'h0);
                end else begin
                    m_e   = exp_fx.pop_front();
                    m_exp = {m_e.cyc[15:0], m_e.is_rd, m_e.sel, m_e.addr, m_e.is_rd ? 8'h00 : m_e.data};
                    check(m_e.is_rd ? "fx_rd_event" : "fx_wr_event", m_act == m_exp && !(fx_wr && fx_rd), m_act, m_exp);
                end
            end else begin
                check("fx_sel_idle", fx_sel == '0, 64'(fx_sel), 64'h0);
            end
            if (ufx_qvld) begin
                m_act = {32'h0, cyc[15:0], 8'h00, ufx_q};
                if (exp_q.size() == 0) begin
                    check("qvld_unexpected", 1'b0, m_act, 64'h0);
                end else begin
                    m_q   = exp_q.pop_front();
                    m_exp = {32'h0, m_q.cyc[15:0], 8'h00, m_q.q};
                    check("read_return", m_act == m_exp, m_act, m_exp);
                end
            end
            check("busy", ufx_busy == (cyc >= busy_from && cyc <= busy_to), 64'(ufx_busy),
                  64'(cyc >= busy_from && cyc <= busy_to));
        end
    end

    // Issue one request at the current cycle; optionally fire ignored strobes the following cycle.
    task automatic do_req(input bit w, input bit r, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [AW-1:0] ra, input bit drop_w, input bit drop_r, input bit ff_lanes);
        int t, tr;
        fx_ev_t e;
        q_ev_t  q;
        t = cyc;
        if (t > busy_to) begin
            busy_from = t + 1;
            busy_to   = t + 1;
            if (w) begin
                e.cyc = t + 1; e.is_rd = 1'b0; e.addr = wa; e.data = wd; e.sel = ref_sel(wa);
                exp_fx.push_back(e);
                if (ref_idx(wa) >= NSLV) exp_err++;
            end
            if (r) begin
                tr = w ? t + 2 : t + 1;
                e.cyc = tr; e.is_rd = 1'b1; e.addr = ra; e.data = '0; e.sel = ref_sel(ra);
                exp_fx.push_back(e);
                for (int i = 0; i < NSLV; i++) slv_val[i*DW +: DW] = ff_lanes ? 8'hFF : 8'($urandom);
                if (ref_idx(ra) >= NSLV) begin
                    exp_err++;
                    q.q = DFLT;
                end else begin
                    if (ff_lanes) slv_val[ref_idx(ra)*DW +: DW] = 8'hC3;
                    q.q = slv_val[ref_idx(ra)*DW +: DW];
                end
                slv_cycle = tr + RD_LAT;
                q.cyc     = tr + 1 + RD_LAT;
                exp_q.push_back(q);
                busy_to = tr + 1 + RD_LAT;
            end
        end else begin
            exp_err += int'(w) + int'(r);
        end
        ufx_wr = w; ufx_rd = r; ufx_waddr = wa; ufx_data = wd; ufx_raddr = ra;
        @(posedge clk_sys); #1;
        ufx_wr = drop_w && (cyc <= busy_to);
        ufx_rd = drop_r && (cyc <= busy_to);
        ufx_waddr = 22'($urandom); ufx_raddr = 22'($urandom); ufx_data = 8'($urandom);
        exp_err += int'(ufx_wr) + int'(ufx_rd);
        @(posedge clk_sys); #1;
        ufx_wr = 1'b0; ufx_rd = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cyc <= busy_to && n < 40) begin
            @(posedge clk_sys); #1;
            n++;
        end
        if (n >= 40) check("idle_timeout", 1'b0, 64'(n), 64'(40));
    endtask

    task automatic check_err();
`ifdef FX_BUS_ERRCNT_EN
        check("err_cnt", err_cnt == 16'(exp_err), 64'(err_cnt), 64'(exp_err));
`endif
    endtask

    function automatic logic [AW-1:0] rand_addr(input int idx);
        return AW'((idx << 17) | ($urandom & 32'h1FFFF));
    endfunction

    initial begin
        bit w, r, dw, dr;
        int kind;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_fx_wr",  fx_wr == 1'b0, 64'(fx_wr), 64'h0);
        check("rst_fx_rd",  fx_rd == 1'b0, 64'(fx_rd), 64'h0);
        check("rst_fx_sel", fx_sel == '0, 64'(fx_sel), 64'h0);
        check("rst_addr",   {fx_waddr, fx_raddr, fx_data} == '0, 64'({fx_waddr, fx_raddr, fx_data}), 64'h0);
        check("rst_ufx",    {ufx_q, ufx_qvld, ufx_busy} == '0, 64'({ufx_q, ufx_qvld, ufx_busy}), 64'h0);
        rst_n = 1'b1;
        @(posedge clk_sys); #1;

        do_req(1'b1, 1'b0, 22'h040010, 8'h5A, '0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        do_req(1'b0, 1'b1, '0, '0, 22'h200004, 1'b0, 1'b0, 1'b1);
        wait_idle();
        do_req(1'b1, 1'b1, rand_addr(1), 8'h77, rand_addr(3), 1'b0, 1'b0, 1'b0);
        wait_idle();
        check_err();
        do_req(1'b0, 1'b1, '0, '0, 22'h3E0000, 1'b0, 1'b0, 1'b0);
        wait_idle();
        check_err();
        do_req(1'b0, 1'b1, '0, '0, rand_addr(5), 1'b0, 1'b1, 1'b0);
        wait_idle();
        check_err();

        for (int k = 0; k < 150; k++) begin
            kind = $urandom_range(0, 2);
            w  = (kind != 1);
            r  = (kind != 0);
            dw = ($urandom_range(0, 7) == 0);
            dr = ($urandom_range(0, 7) == 0);
            do_req(w, r, rand_addr($urandom_range(0, 31)), 8'($urandom),
                   rand_addr($urandom_range(0, 31)), dw, dr, 1'b0);
            wait_idle();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_sys); #1;
            end
        end
        check_err();

        do_req(1'b0, 1'b1, '0, '0, rand_addr(7), 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_fx",  {fx_wr, fx_rd, fx_sel} == '0, 64'({fx_wr, fx_rd, fx_sel}), 64'h0);
        check("rst_mid_ufx", {ufx_q, ufx_qvld, ufx_busy} == '0, 64'({ufx_q, ufx_qvld, ufx_busy}), 64'h0);
        exp_fx.delete();
        exp_q.delete();
        busy_from = -10; busy_to = -10; slv_cycle = -10; exp_err = 0;
        repeat (2) @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        check_err();
        do_req(1'b0, 1'b1, '0, '0, rand_addr(0), 1'b0, 1'b0, 1'b0);
        wait_idle();
        repeat (3) @(posedge clk_sys);
        #1;
        check("fx_queue_drained", exp_fx.size() == 0, 64'(exp_fx.size()), 64'h0);
        check("q_queue_drained",  exp_q.size() == 0,  64'(exp_q.size()),  64'h0);
        check_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
